// File: rtl/alsu_req_arbiter.sv
// rtl/alsu_req_arbiter.sv - round-robin arbiter sharing one ALSU among several requesters
//
// Purpose:
//   Grants one requester per cycle (round-robin, with an optional lock for
//   back-to-back shift/rotate chains), drives the registered ALSU command,
//   tracks in-flight ops in a tag pipeline and returns each result with its
//   requester id and invalid-op flag through a credit-limited FWFT FIFO.
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   req_valid/req_lock/req_cmd    per-requester request, lock and 16-bit command
//   req_ready                     one-hot combinational accept
//   alsu_rst                      reset pass-through to the ALSU
//   alsu_opcode .. alsu_direction registered command fields to the ALSU
//   alsu_out                      ALSU result
//   rsp_valid/rsp_ready           response FIFO head handshake
//   rsp_id/rsp_data/rsp_err       head requester index, captured result, invalid flag
module alsu_req_arbiter #(
  parameter int NUM_REQ   = 4,
  parameter int ALSU_LAT  = 2,
  parameter int RSP_DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_REQ-1:0]         req_valid,
  input  logic [NUM_REQ-1:0]         req_lock,
  input  logic [16*NUM_REQ-1:0]      req_cmd,
  output logic [NUM_REQ-1:0]         req_ready,
  output logic                       alsu_rst,
  output logic [2:0]                 alsu_opcode,
  output logic [2:0]                 alsu_a,
  output logic [2:0]                 alsu_b,
  output logic                       alsu_cin,
  output logic                       alsu_serial_in,
  output logic                       alsu_red_op_a,
  output logic                       alsu_red_op_b,
  output logic                       alsu_bypass_a,
  output logic                       alsu_bypass_b,
  output logic                       alsu_direction,
  input  logic [5:0]                 alsu_out,
  output logic                       rsp_valid,
  input  logic                       rsp_ready,
  output logic [$clog2(NUM_REQ)-1:0] rsp_id,
  output logic [5:0]                 rsp_data,
  output logic                       rsp_err
);

  localparam int IDW = $clog2(NUM_REQ);
  localparam int AW  = $clog2(RSP_DEPTH);
  localparam int CW  = AW + 1;
  localparam int OW  = CW + 1;
  localparam int EW  = 7 + IDW;

  logic [IDW-1:0]                rr_q;
  logic                          lock_valid_q;
  logic [IDW-1:0]                lock_id_q;
  logic [15:0]                   cmd_q;
  logic [ALSU_LAT:0]             tag_valid_q;
  logic [ALSU_LAT:0][IDW-1:0]    tag_id_q;
  logic [ALSU_LAT:0]             tag_err_q;
  logic [RSP_DEPTH-1:0][EW-1:0]  mem;
  logic [AW-1:0]                 wr_ptr;
  logic [AW-1:0]                 rd_ptr;
  logic [CW-1:0]                 count;

  logic           grant_any;
  logic [IDW-1:0] grant_idx;
  logic [15:0]    sel_cmd;
  logic           sel_err;
  logic [OW-1:0]  occ;
  logic           credit_ok;
  logic           hs;
  logic           push;
  logic           pop;
  logic [EW-1:0]  head;

  assign alsu_rst = rst;
  assign {alsu_opcode, alsu_a, alsu_b, alsu_cin, alsu_serial_in, alsu_red_op_a,
          alsu_red_op_b, alsu_bypass_a, alsu_bypass_b, alsu_direction} = cmd_q;

  assign push = tag_valid_q[ALSU_LAT];
  assign pop  = rsp_valid & rsp_ready;

  // Every slot is reserved at grant time: ops still in the tag pipe count
  // against the FIFO so a push can never find it full.
  always_comb begin
    occ = OW'(count);
    for (int k = 0; k <= ALSU_LAT; k++) begin
      occ = occ + OW'(tag_valid_q[k]);
    end
  end

  // A pop this cycle frees a slot for a grant this cycle.
  assign credit_ok = pop | (occ < OW'(RSP_DEPTH));

  always_comb begin
    int c;
    c         = 0;
    grant_any = 1'b0;
    grant_idx = '0;
    if (lock_valid_q && req_valid[lock_id_q]) begin
      grant_any = 1'b1;
      grant_idx = lock_id_q;
    end else begin
      for (int k = 1; k <= NUM_REQ; k++) begin
        c = int'(rr_q) + k;
        if (c >= NUM_REQ) c = c - NUM_REQ;
        if (!grant_any && req_valid[c]) begin
          grant_any = 1'b1;
          grant_idx = IDW'(c);
        end
      end
    end
  end

  assign hs = grant_any & credit_ok & ~rst;

  always_comb begin
    req_ready = '0;
    if (hs) req_ready[grant_idx] = 1'b1;
  end

  always_comb begin
    sel_cmd = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (grant_idx == IDW'(k)) sel_cmd = req_cmd[16*k +: 16];
    end
  end

  // Bypass wins over everything; otherwise opcodes 6/7 and reductions on
  // arithmetic/shift opcodes make the ALSU force its output to zero.
  assign sel_err = ~sel_cmd[2] & ~sel_cmd[1] &
                   ((sel_cmd[15:13] >= 3'd6) |
                    ((sel_cmd[15:13] >= 3'd2) & (sel_cmd[4] | sel_cmd[3])));

  always_ff @(posedge clk) begin
    if (rst) begin
      rr_q         <= IDW'(NUM_REQ - 1);
      lock_valid_q <= 1'b0;
      lock_id_q    <= '0;
      cmd_q        <= '0;
      tag_valid_q  <= '0;
      tag_id_q     <= '0;
      tag_err_q    <= '0;
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      count        <= '0;
    end else begin
      // Idle cycles drive an all-zero command so the ALSU settles to 0.
      cmd_q       <= hs ? sel_cmd : 16'h0;
      tag_valid_q <= {tag_valid_q[ALSU_LAT-1:0], hs};
      tag_id_q    <= {tag_id_q[ALSU_LAT-1:0], grant_idx};
      tag_err_q   <= {tag_err_q[ALSU_LAT-1:0], sel_err};
      if (hs) begin
        rr_q         <= grant_idx;
        lock_valid_q <= req_lock[grant_idx];
        lock_id_q    <= grant_idx;
      end else if (lock_valid_q && !req_valid[lock_id_q]) begin
        lock_valid_q <= 1'b0;
      end
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= {tag_err_q[ALSU_LAT], tag_id_q[ALSU_LAT], alsu_out};
  end

  assign head      = mem[rd_ptr];
  assign rsp_valid = (count != '0);
  assign rsp_data  = rsp_valid ? head[5:0] : 6'h0;
  assign rsp_id    = rsp_valid ? head[IDW+5:6] : '0;
  assign rsp_err   = rsp_valid & head[EW-1];

  no_fifo_overflow: assert property (@(posedge clk) disable iff (rst)
    !(push && !pop && count == CW'(RSP_DEPTH)));

endmodule

// File: tb/tb_alsu_req_arbiter.sv
// tb/tb_alsu_req_arbiter.sv - self-checking bench for alsu_req_arbiter with a behavioural ALSU
module tb_alsu_req_arbiter;

  localparam int N = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic [N-1:0]  req_valid;
  logic [N-1:0]  req_lock;
  logic [16*N-1:0] req_cmd;
  logic [N-1:0]  req_ready;
  logic          alsu_rst;
  logic [2:0]    alsu_opcode, alsu_a, alsu_b;
  logic          alsu_cin, alsu_serial_in, alsu_red_op_a, alsu_red_op_b;
  logic          alsu_bypass_a, alsu_bypass_b, alsu_direction;
  logic [5:0]    alsu_out;
  logic          rsp_valid;
  logic          rsp_ready;
  logic [1:0]    rsp_id;
  logic [5:0]    rsp_data;
  logic          rsp_err;

  always #5 clk = ~clk;

  alsu_req_arbiter #(.NUM_REQ(N), .ALSU_LAT(2), .RSP_DEPTH(4)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_lock(req_lock), .req_cmd(req_cmd), .req_ready(req_ready),
    .alsu_rst(alsu_rst), .alsu_opcode(alsu_opcode), .alsu_a(alsu_a), .alsu_b(alsu_b),
    .alsu_cin(alsu_cin), .alsu_serial_in(alsu_serial_in),
    .alsu_red_op_a(alsu_red_op_a), .alsu_red_op_b(alsu_red_op_b),
    .alsu_bypass_a(alsu_bypass_a), .alsu_bypass_b(alsu_bypass_b),
    .alsu_direction(alsu_direction), .alsu_out(alsu_out),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_id(rsp_id), .rsp_data(rsp_data), .rsp_err(rsp_err)
  );

  // Behavioural ALSU: inputs registered, output registered (2-cycle latency).
  logic [15:0] in_q;
  logic [5:0]  out_r;
  assign alsu_out = out_r;

  function automatic logic [5:0] alsu_f(input logic [15:0] c, input logic [5:0] o);
    logic [2:0] op, a, b;
    logic cin, si, ra, rb, ba, bb, dir;
    logic [5:0] sa, sb;
    logic bad;
    {op, a, b, cin, si, ra, rb, ba, bb, dir} = c;
    sa  = {{3{a[2]}}, a};
    sb  = {{3{b[2]}}, b};
    bad = (op >= 3'd6) | ((op >= 3'd2) & (ra | rb));
    if (ba) return sa;
    if (bb) return sb;
    if (bad) return 6'h0;
    case (op)
      3'd0: return ra ? {5'b0, |a} : (rb ? {5'b0, |b} : (sa | sb));
      3'd1: return ra ? {5'b0, ^a} : (rb ? {5'b0, ^b} : (sa ^ sb));
      3'd2: return sa + sb + {5'b0, cin};
      3'd3: return 6'(signed'(sa) * signed'(sb));
      3'd4: return dir ? {o[4:0], si} : {si, o[5:1]};
      default: return dir ? {o[4:0], o[5]} : {o[0], o[5:1]};
    endcase
  endfunction

  always @(posedge clk) begin
    if (alsu_rst) begin
      in_q  <= 16'h0;
      out_r <= 6'h0;
    end else begin
      in_q  <= {alsu_opcode, alsu_a, alsu_b, alsu_cin, alsu_serial_in, alsu_red_op_a,
                alsu_red_op_b, alsu_bypass_a, alsu_bypass_b, alsu_direction};
      out_r <= alsu_f(in_q, out_r);
    end
  end

  typedef struct packed {
    logic [1:0] id;
    logic [5:0] data;
    logic       err;
  } rsp_t;

  rsp_t rq[$];

  always @(negedge clk) begin
    if (!rst && rsp_valid && rsp_ready) rq.push_back({rsp_id, rsp_data, rsp_err});
  end

  typedef struct packed {
    logic [1:0]  id;
    logic [15:0] cmd;
    logic [5:0]  data;
    logic        err;
  } vec_t;

  vec_t vecs[11];
  int   tests_run = 0;
  int   tests_failed = 0;

  function automatic logic [15:0] mk(input logic [2:0] op, input logic [2:0] a, input logic [2:0] b,
                                     input logic cin, input logic si, input logic ra, input logic rb,
                                     input logic ba, input logic bb, input logic dir);
    return {op, a, b, cin, si, ra, rb, ba, bb, dir};
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    req_valid = '0;
    req_lock = '0;
    req_cmd = '0;
    rsp_ready = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    rq.delete();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int hs_cnt;
    int got_rsp;
    rsp_t r;
    int exp2[5];
    logic [1:0] exp4_id[5];
    logic [5:0] exp4_data[5];

    exp2 = '{0, 1, 2, 3, 0};
    exp4_id = '{2'd1, 2'd1, 2'd1, 2'd1, 2'd2};
    exp4_data = '{6'h3F, 6'h3F, 6'h3F, 6'h3F, 6'h03};

    vecs[0]  = '{2'd0, mk(3'd2, 3'd3, 3'd1, 1, 0, 0, 0, 0, 0, 0), 6'h05, 1'b0};
    vecs[1]  = '{2'd1, mk(3'd0, 3'd1, 3'd2, 0, 0, 0, 0, 0, 0, 0), 6'h03, 1'b0};
    vecs[2]  = '{2'd2, mk(3'd1, 3'd3, 3'd1, 0, 0, 0, 0, 0, 0, 0), 6'h02, 1'b0};
    vecs[3]  = '{2'd3, mk(3'd3, 3'b110, 3'd3, 0, 0, 0, 0, 0, 0, 0), 6'h3A, 1'b0};
    vecs[4]  = '{2'd3, mk(3'd6, 3'd1, 3'd1, 0, 0, 0, 0, 0, 0, 0), 6'h00, 1'b1};
    vecs[5]  = '{2'd3, mk(3'd3, 3'd0, 3'b110, 0, 0, 1, 0, 0, 1, 0), 6'h3E, 1'b0};
    vecs[6]  = '{2'd2, mk(3'd7, 3'd2, 3'd2, 0, 0, 0, 0, 0, 0, 0), 6'h00, 1'b1};
    vecs[7]  = '{2'd1, mk(3'd2, 3'd1, 3'd1, 0, 0, 0, 1, 0, 0, 0), 6'h00, 1'b1};
    vecs[8]  = '{2'd0, mk(3'd7, 3'b100, 3'd1, 0, 0, 0, 0, 1, 1, 0), 6'h3C, 1'b0};
    vecs[9]  = '{2'd0, mk(3'd0, 3'd2, 3'd0, 0, 0, 1, 0, 0, 0, 0), 6'h01, 1'b0};
    vecs[10] = '{2'd1, mk(3'd2, 3'b111, 3'b111, 0, 0, 0, 0, 0, 0, 0), 6'h3E, 1'b0};

    // Reset state, with every requester asking.
    rst = 1'b1;
    req_valid = 4'hF;
    req_lock = '0;
    req_cmd = '0;
    rsp_ready = 1'b1;
    tick();
    check("rst_req_ready", 32'(req_ready), 32'h0);
    check("rst_rsp_valid", 32'(rsp_valid), 32'h0);
    check("rst_alsu_opcode", 32'(alsu_opcode), 32'h0);
    check("rst_rsp_data", 32'(rsp_data), 32'h0);
    check("rst_alsu_rst", 32'(alsu_rst), 32'h1);
    do_reset();

    // Single op latency: issue at t, cmd at t+1, response at t+4.
    req_valid = 4'b0001;
    req_cmd[15:0] = mk(3'd2, 3'd3, 3'd1, 1, 0, 0, 0, 0, 0, 0);
    #1 check("t1_ready", 32'(req_ready), 32'h1);
    tick();
    req_valid = '0;
    check("t1_alsu_opcode", 32'(alsu_opcode), 32'h2);
    check("t1_alsu_a", 32'(alsu_a), 32'h3);
    check("t1_alsu_cin", 32'(alsu_cin), 32'h1);
    tick();
    check("t1_rsp_valid_t2", 32'(rsp_valid), 32'h0);
    check("t1_alsu_idle", 32'(alsu_opcode), 32'h0);
    tick();
    check("t1_rsp_valid_t3", 32'(rsp_valid), 32'h0);
    tick();
    check("t1_rsp_valid_t4", 32'(rsp_valid), 32'h1);
    check("t1_rsp_id", 32'(rsp_id), 32'h0);
    check("t1_rsp_data", 32'(rsp_data), 32'h05);
    check("t1_rsp_err", 32'(rsp_err), 32'h0);
    tick();
    rq.delete();

    // Table of single ops across requesters.
    for (int i = 0; i < 11; i++) begin
      req_valid = '0;
      req_valid[vecs[i].id] = 1'b1;
      req_cmd[16*vecs[i].id +: 16] = vecs[i].cmd;
      #1 check($sformatf("vec%0d_ready", i), 32'(req_ready), 32'(4'b0001 << vecs[i].id));
      tick();
      req_valid = '0;
      got_rsp = 0;
      for (int w = 0; w < 10 && got_rsp == 0; w++) begin
        if (rq.size() > 0) got_rsp = 1;
        else tick();
      end
      check($sformatf("vec%0d_rsp_seen", i), 32'(got_rsp), 32'h1);
      if (got_rsp != 0) begin
        r = rq.pop_front();
        check($sformatf("vec%0d_id", i), 32'(r.id), 32'(vecs[i].id));
        check($sformatf("vec%0d_data", i), 32'(r.data), 32'(vecs[i].data));
        check($sformatf("vec%0d_err", i), 32'(r.err), 32'(vecs[i].err));
      end
    end

    // Round-robin order from reset with everyone requesting.
    do_reset();
    req_valid = 4'hF;
    for (int c = 0; c < 5; c++) begin
      #1 check($sformatf("t2_grant%0d", c), 32'(req_ready), 32'(4'b0001 << exp2[c]));
      tick();
    end
    req_valid = '0;
    repeat (8) tick();
    check("t2_rsp_count", 32'(rq.size()), 32'd5);

    // Credit limit: no pops -> exactly RSP_DEPTH grants, then pop frees one same cycle.
    do_reset();
    rsp_ready = 1'b0;
    req_valid = 4'b0001;
    hs_cnt = 0;
    for (int c = 0; c < 10; c++) begin
      #1 if (req_ready[0]) hs_cnt++;
      tick();
    end
    check("t3_handshakes", 32'(hs_cnt), 32'd4);
    #1 check("t3_blocked", 32'(req_ready), 32'h0);
    rsp_ready = 1'b1;
    #1 check("t3_pop_grant", 32'(req_ready), 32'h1);
    tick();
    req_valid = '0;
    repeat (8) tick();
    check("t3_rsp_count", 32'(rq.size()), 32'd5);
    rq.delete();

    // Locked shift chain on req1 holds off req2 until the lock is released.
    do_reset();
    req_valid = 4'b0110;
    req_lock = 4'b0010;
    req_cmd[31:16] = mk(3'd0, 3'b111, 3'd0, 0, 0, 0, 0, 1, 0, 0);
    req_cmd[47:32] = mk(3'd1, 3'd1, 3'd2, 0, 0, 0, 0, 0, 0, 0);
    #1 check("t4_first", 32'(req_ready), 32'h2);
    tick();
    for (int s = 0; s < 3; s++) begin
      req_cmd[31:16] = mk(3'd4, 3'd0, 3'd0, 0, 1, 0, 0, 0, 0, 1);
      req_lock[1] = (s < 2);
      #1 check($sformatf("t4_locked%0d", s), 32'(req_ready), 32'h2);
      tick();
    end
    #1 check("t4_release", 32'(req_ready), 32'h4);
    tick();
    req_valid = '0;
    req_lock = '0;
    repeat (8) tick();
    check("t4_rsp_count", 32'(rq.size()), 32'd5);
    for (int k = 0; k < 5; k++) begin
      if (rq.size() > 0) begin
        r = rq.pop_front();
        check($sformatf("t4_id%0d", k), 32'(r.id), 32'(exp4_id[k]));
        check($sformatf("t4_data%0d", k), 32'(r.data), 32'(exp4_data[k]));
      end
    end

    // Reset with three ops in flight discards them.
    do_reset();
    rsp_ready = 1'b0;
    req_valid = 4'b0001;
    req_cmd[15:0] = mk(3'd2, 3'd1, 3'd1, 0, 0, 0, 0, 0, 0, 0);
    for (int c = 0; c < 3; c++) begin
      #1 check($sformatf("t6_issue%0d", c), 32'(req_ready), 32'h1);
      tick();
    end
    req_valid = '0;
    rst = 1'b1;
    #1 check("t6_ready_in_rst", 32'(req_ready), 32'h0);
    tick();
    check("t6_rsp_valid_after_rst", 32'(rsp_valid), 32'h0);
    rst = 1'b0;
    rsp_ready = 1'b1;
    repeat (8) tick();
    check("t6_no_stale", 32'(rq.size()), 32'd0);
    check("t6_rsp_valid_end", 32'(rsp_valid), 32'h0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
